// File: rtl/display_source_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : display_source_arbiter_if
//  Brief    : Requester frames, ownership grants and segment codes for the
//             shared 4-digit display arbiter.
//  Revision : 1.0
// ============================================================================
interface display_source_arbiter_if;
    logic        req_a;
    logic [15:0] data_a;
    logic [3:0]  dp_a;
    logic        req_b;
    logic [15:0] data_b;
    logic [3:0]  dp_b;
    logic        grant_a;
    logic        grant_b;
    logic [7:0]  salidaDisplay1;
    logic [7:0]  salidaDisplay2;
    logic [7:0]  salidaDisplay3;
    logic [7:0]  salidaDisplay4;

    // Requester side: drives requests and frames, observes grants and codes.
    modport master (
        output req_a, data_a, dp_a, req_b, data_b, dp_b,
        input  grant_a, grant_b,
        input  salidaDisplay1, salidaDisplay2, salidaDisplay3, salidaDisplay4
    );

    modport slave (
        input  req_a, data_a, dp_a, req_b, data_b, dp_b,
        output grant_a, grant_b,
        output salidaDisplay1, salidaDisplay2, salidaDisplay3, salidaDisplay4
    );
endinterface
`default_nettype wire

// File: rtl/display_source_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : display_source_arbiter
//  Brief    : Shares a 4-digit 7-segment display between two requesters with
//             alternating priority and a minimum hold time; registers the
//             owner's frame as active-low segment codes.
//  Revision : 1.0
// ============================================================================
module display_source_arbiter #(
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = 10
) (
    input wire                      clk,
    input wire                      reset,
    display_source_arbiter_if.slave bus
);

    localparam logic [1:0]       c_ST_IDLE   = 2'd0;
    localparam logic [1:0]       c_ST_SHOW_A = 2'd1;
    localparam logic [1:0]       c_ST_SHOW_B = 2'd2;
    localparam logic             c_OWNER_A   = 1'b0;
    localparam logic             c_OWNER_B   = 1'b1;
    localparam logic [CNT_W-1:0] c_HOLD_MAX  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]       c_BLANK     = 8'hFF;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_last_owner;
    logic             r_grant_a;
    logic             r_grant_b;
    logic             w_sample;
    logic             w_enter;
    logic             w_hold_done;
    logic [15:0]      w_frame_data;
    logic [3:0]       w_frame_dp;
    logic [7:0]       w_code [4];
    logic [7:0]       r_seg  [4];

    // Segment code {dp,g,f,e,d,c,b,a}, active-low; A..E render as a dash.
    function automatic logic [7:0] f_encode_digit(input logic [3:0] nib, input logic dp);
        logic [6:0] v_seg;
        case (nib)
            4'h0:    v_seg = 7'h40;
            4'h1:    v_seg = 7'h79;
            4'h2:    v_seg = 7'h24;
            4'h3:    v_seg = 7'h30;
            4'h4:    v_seg = 7'h19;
            4'h5:    v_seg = 7'h12;
            4'h6:    v_seg = 7'h02;
            4'h7:    v_seg = 7'h78;
            4'h8:    v_seg = 7'h00;
            4'h9:    v_seg = 7'h10;
            4'hF:    v_seg = 7'h7F;
            default: v_seg = 7'h3F;
        endcase
        return {~dp, v_seg};
    endfunction

    assign w_hold_done = (r_hold_cnt == c_HOLD_MAX);

    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.req_a && !bus.req_b)
                    w_next_state = c_ST_SHOW_A;
                else if (bus.req_b && !bus.req_a)
                    w_next_state = c_ST_SHOW_B;
                else if (bus.req_a && bus.req_b)
                    w_next_state = (r_last_owner == c_OWNER_B) ? c_ST_SHOW_A : c_ST_SHOW_B;
            end
            c_ST_SHOW_A: begin
                w_sample = bus.req_a;
                if (bus.req_a) begin
                    if (bus.req_b && w_hold_done)
                        w_next_state = c_ST_SHOW_B;
                end else begin
                    w_next_state = bus.req_b ? c_ST_SHOW_B : c_ST_IDLE;
                end
            end
            c_ST_SHOW_B: begin
                w_sample = bus.req_b;
                if (bus.req_b) begin
                    if (bus.req_a && w_hold_done)
                        w_next_state = c_ST_SHOW_A;
                end else begin
                    w_next_state = bus.req_a ? c_ST_SHOW_A : c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Any move into a SHOW state, from IDLE or the other owner, restarts the hold.
    assign w_enter = (w_next_state != r_state) && (w_next_state != c_ST_IDLE);

    assign w_frame_data = (r_state == c_ST_SHOW_A) ? bus.data_a : bus.data_b;
    assign w_frame_dp   = (r_state == c_ST_SHOW_A) ? bus.dp_a   : bus.dp_b;

    // Index 0 is the rightmost digit (lowest nibble).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign w_code[gi] = f_encode_digit(w_frame_data[4*gi +: 4], w_frame_dp[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_grant_a    <= 1'b0;
            r_grant_b    <= 1'b0;
            r_hold_cnt   <= '0;
            r_last_owner <= c_OWNER_B;
        end else begin
            r_state   <= w_next_state;
            r_grant_a <= (w_next_state == c_ST_SHOW_A);
            r_grant_b <= (w_next_state == c_ST_SHOW_B);
            if (w_enter) begin
                r_hold_cnt   <= '0;
                r_last_owner <= (w_next_state == c_ST_SHOW_A) ? c_OWNER_A : c_OWNER_B;
            end else if ((r_state != c_ST_IDLE) && !w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_seg[i] <= c_BLANK;
        end else if (w_sample) begin
            for (int i = 0; i < 4; i++) r_seg[i] <= w_code[i];
        end
    end

    assign bus.grant_a        = r_grant_a;
    assign bus.grant_b        = r_grant_b;
    assign bus.salidaDisplay1 = r_seg[3];
    assign bus.salidaDisplay2 = r_seg[2];
    assign bus.salidaDisplay3 = r_seg[1];
    assign bus.salidaDisplay4 = r_seg[0];

endmodule
`default_nettype wire

// File: tb/tb_display_source_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_source_arbiter
//  Brief    : Directed self-checking bench for display_source_arbiter.
//  Revision : 1.0
// ============================================================================
module tb_display_source_arbiter;

    logic r_clk   = 1'b0;
    logic r_reset = 1'b0;
    int   r_total = 0;
    int   r_bad   = 0;

    display_source_arbiter_if bus ();

    display_source_arbiter #(
        .HOLD_CYCLES (4),
        .CNT_W       (2)
    ) u_dut (
        .clk   (r_clk),
        .reset (r_reset),
        .bus   (bus)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_total++;
        if (obs !== exp) begin
            r_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] seg();
        return {bus.salidaDisplay1, bus.salidaDisplay2, bus.salidaDisplay3, bus.salidaDisplay4};
    endfunction

    initial begin
        logic exp_a;
        logic prev_a;
        bus.req_a  = 1'b0;  bus.data_a = '0;  bus.dp_a = '0;
        bus.req_b  = 1'b0;  bus.data_b = '0;  bus.dp_b = '0;

        // Reset held, then released with no requests
        repeat (3) @(negedge r_clk);
        check("rst_ga",  32'(bus.grant_a), 32'd0);
        check("rst_gb",  32'(bus.grant_b), 32'd0);
        check("rst_seg", seg(), 32'hFFFF_FFFF);
        r_reset = 1'b1;
        repeat (2) @(negedge r_clk);
        check("idle_ga",  32'(bus.grant_a), 32'd0);
        check("idle_gb",  32'(bus.grant_b), 32'd0);
        check("idle_seg", seg(), 32'hFFFF_FFFF);

        // Single requester A
        bus.data_a = 16'h1234; bus.dp_a = 4'b0100; bus.req_a = 1'b1;
        @(negedge r_clk);
        check("a_grant",   32'(bus.grant_a), 32'd1);
        check("a_grant_b", 32'(bus.grant_b), 32'd0);
        check("a_lat_seg", seg(), 32'hFFFF_FFFF);
        @(negedge r_clk);
        check("a_frame", seg(), 32'hF924_B099);
        bus.data_a = 16'h5678; bus.dp_a = 4'b0000;
        @(negedge r_clk);
        check("a_live", seg(), 32'h9282_F880);
        bus.req_a = 1'b0;
        @(negedge r_clk);
        check("a_drop_ga",  32'(bus.grant_a), 32'd0);
        check("a_drop_gb",  32'(bus.grant_b), 32'd0);
        check("a_drop_seg", seg(), 32'h9282_F880);

        // Mid-run reset, then both request: A first, then B after A drops
        r_reset = 1'b0;
        @(negedge r_clk);
        check("rst2_seg", seg(), 32'hFFFF_FFFF);
        r_reset = 1'b1;
        bus.data_b = 16'hFFF0; bus.dp_b = 4'b0000;
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        @(negedge r_clk);
        check("both_ga", 32'(bus.grant_a), 32'd1);
        check("both_gb", 32'(bus.grant_b), 32'd0);
        bus.req_a = 1'b0;
        @(negedge r_clk);
        check("handoff_gb",  32'(bus.grant_b), 32'd1);
        check("handoff_ga",  32'(bus.grant_a), 32'd0);
        check("handoff_seg", seg(), 32'hFFFF_FFFF);
        @(negedge r_clk);
        check("b_frame", seg(), 32'hFFFF_FFC0);
        bus.data_b = 16'h0A9F; bus.dp_b = 4'b0001;
        @(negedge r_clk);
        check("b_dash_dp", seg(), 32'hC0BF_907F);
        bus.req_b = 1'b0;
        @(negedge r_clk);
        check("b_drop_gb",  32'(bus.grant_b), 32'd0);
        check("b_drop_seg", seg(), 32'hC0BF_907F);

        // Hold time: A owns, B joins on A's first cycle, ownership alternates every 4
        bus.data_a = 16'h1111; bus.dp_a = 4'b0000;
        bus.data_b = 16'h2222; bus.dp_b = 4'b0000;
        bus.req_a = 1'b1;
        prev_a = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge r_clk);
            exp_a = (((i - 1) / 4) % 2) == 0;
            check($sformatf("hold_ga_%0d", i), 32'(bus.grant_a), 32'(exp_a));
            check($sformatf("hold_gb_%0d", i), 32'(bus.grant_b), 32'(!exp_a));
            if (i >= 2)
                check($sformatf("hold_seg_%0d", i), seg(), prev_a ? 32'hF9F9_F9F9 : 32'hA4A4_A4A4);
            prev_a = exp_a;
            if (i == 1) bus.req_b = 1'b1;
        end

        // Asynchronous reset while B owns: blank before the next rising edge
        #2 r_reset = 1'b0;
        #1;
        check("async_seg", seg(), 32'hFFFF_FFFF);
        check("async_gb",  32'(bus.grant_b), 32'd0);
        check("async_ga",  32'(bus.grant_a), 32'd0);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
